mem_wb_reg: RTL
===============

# mem_wb_reg

Pipeline register and load-writeback stage between the MEM stage and the register file / HI-LO unit. It captures MEM-stage results when the data access completes and aligns and extends load data per load type. It inserts bubbles while MEM is stalled, squashes on pipeline flush, and keeps retirement and stall performance counters.

## Interface

Parameters
- `REG_AW`, 7: register-address width; matches MEM's `WriteRegisterW`.

Ports
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `stall_mem`  in  1  MEM stage stall (cache miss or uncached access pending)
- `hold_wb`  in  1  downstream freeze; register keeps its contents
- `flush`  in  1  exception/ERET flush from CP0
- `mem_to_reg`  in  1  instruction is a load
- `reg_write`  in  1  instruction writes the GPR file
- `hilo_we`  in  1  HI/LO write enable
- `hilo_data`  in  64  HI/LO value
- `alu_out`  in  32  ALU result / effective address
- `wr_reg`  in  REG_AW  destination register
- `pc_in`  in  32  instruction PC
- `read_type`  in  3  [1:0] size (00 byte, 01 half, 10 word); [2]=1 zero-extend
- `exc_in`  in  4  exception code, 0 = none
- `is_ds_in`  in  1  instruction is in a delay slot
- `mem_data`  in  32  raw word from MEM (cache or uncached path)
- `wb_valid`  out  1  register holds a live instruction
- `wb_reg_we`  out  1  GPR write enable
- `wb_reg_addr`  out  REG_AW  GPR address
- `wb_reg_data`  out  32  GPR write data
- `wb_hilo_we`  out  1  HI/LO write enable
- `wb_hilo_data`  out  64  HI/LO data
- `wb_pc`  out  32  retired PC
- `wb_exc`  out  4  exception code
- `wb_is_ds`  out  1  delay-slot flag
- `retire_cnt`  out  32  retired instructions without exception
- `stall_cnt`  out  32  cycles with `stall_mem` asserted

## Operation

- Update priority each cycle: `rst` > `flush` > `hold_wb` > `stall_mem` > capture.
- Reset and flush: all outputs go to 0, including `wb_valid`. Counters clear on `rst` only. Flush does not clear counters.
- Hold: every register, counters included, keeps its value. `stall_cnt` still counts if `stall_mem`=1.
- Stall (no hold): bubble is inserted. `wb_valid`, `wb_reg_we` and `wb_hilo_we` go to 0. Other fields keep their values.
- Capture: `wb_valid`<=1. Fields load from the inputs.
  - `wb_reg_we` <= `reg_write` & (`exc_in`==0).
  - `wb_hilo_we` <= `hilo_we` & (`exc_in`==0).
- Write data: `wb_reg_data` = `mem_to_reg` ? aligned load : `alu_out`.
- Load alignment by `read_type`:
  - Byte: lane = `alu_out[1:0]`, selects `mem_data[8*lane+7:8*lane]`. Sign-extended unless [2]=1.
  - Half: `alu_out[1]` selects upper or lower half. Sign-extended unless [2]=1. `alu_out[0]` is ignored; a misaligned address already carries a nonzero `exc_in`, so the write is suppressed.
  - Word: `mem_data` unchanged.
  - Size 11: treated as word.
- `retire_cnt` +1 on every capture with `exc_in`==0.
- `stall_cnt` +1 every cycle with `stall_mem`=1 and `rst`=0.
- Both counters wrap modulo 2^32.

## Timing

- Latency: 1 cycle. Inputs present at rising edge N appear on outputs after edge N.
- `mem_data` is sampled in the first cycle with `stall_mem`=0. MEM guarantees it is valid in that cycle.
- All outputs are registered. No combinational input-to-output path.
- Flush in the same cycle as `stall_mem` or `hold_wb`: flush wins and outputs zero.
- Reset in the middle of a stall: outputs zero next cycle and the stall count restarts from 0.
- Back-to-back captures with no stall: one instruction retires per cycle.

## Test plan

- Word load: `mem_to_reg`=1, `reg_write`=1, `read_type`=010, `alu_out`=0x8000_0010, `mem_data`=0xDEADBEEF, `wr_reg`=5. Next cycle: `wb_reg_we`=1, `wb_reg_addr`=5, `wb_reg_data`=0xDEADBEEF, `retire_cnt`=1.
- Byte loads: `mem_data`=0x80FF7F01.
  - `read_type`=000, `alu_out[1:0]`=11 -> 0xFFFFFF80.
  - `read_type`=100, same lane -> 0x00000080.
  - `read_type`=000, lane 01 -> 0x0000007F.
- Halfword loads: `mem_data`=0x8001_7FFE.
  - `read_type`=001, `alu_out[1]`=1 -> 0xFFFF8001.
  - `read_type`=101, `alu_out[1]`=1 -> 0x00008001.
  - `read_type`=001, `alu_out[1]`=0 -> 0x00007FFE.
- Stall: hold `stall_mem`=1 for 3 cycles with a valid load at the input. Required: `wb_valid`=0 for 3 cycles, `stall_cnt`=3. Capture happens on the 4th edge with the `mem_data` presented then.
- Exception and flush:
  - `exc_in`=4 with `reg_write`=1 -> `wb_reg_we`=0, `wb_exc`=4, `retire_cnt` unchanged.
  - `flush` asserted together with `stall_mem` -> all outputs 0, `stall_cnt` increments.
- Hold and wrap:
  - `hold_wb`=1 for 2 cycles -> outputs unchanged.
  - Counter wrap: `retire_cnt` preloaded to 0xFFFFFFFF (force), then one retire -> 0.

Source files
------------

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load alignment, bubble/flush control and perf counters
// Ports:
//    clk, rst                 clock, synchronous active-high reset
//    stall_mem, hold_wb       MEM stall (inserts bubble), downstream freeze (keeps contents)
//    flush                    CP0 exception/ERET squash
//    mem_to_reg .. is_ds_in   MEM-stage instruction fields
//    mem_data                 raw word returned by the data access
//    wb_*                     registered writeback fields
//    retire_cnt, stall_cnt    retired-without-exception and MEM-stall cycle counters
module mem_wb_reg #(
   parameter int REG_AW = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_mem,
   input  logic              hold_wb,
   input  logic              flush,
   input  logic              mem_to_reg,
   input  logic              reg_write,
   input  logic              hilo_we,
   input  logic [63:0]       hilo_data,
   input  logic [31:0]       alu_out,
   input  logic [REG_AW-1:0] wr_reg,
   input  logic [31:0]       pc_in,
   input  logic [2:0]        read_type,
   input  logic [3:0]        exc_in,
   input  logic              is_ds_in,
   input  logic [31:0]       mem_data,
   output logic              wb_valid,
   output logic              wb_reg_we,
   output logic [REG_AW-1:0] wb_reg_addr,
   output logic [31:0]       wb_reg_data,
   output logic              wb_hilo_we,
   output logic [63:0]       wb_hilo_data,
   output logic [31:0]       wb_pc,
   output logic [3:0]        wb_exc,
   output logic              wb_is_ds,
   output logic [31:0]       retire_cnt,
   output logic [31:0]       stall_cnt
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_data;
   // read_type[1] set covers both word (10) and the unused 11 encoding
   always_comb begin
      lane_b    = mem_data[{alu_out[1:0], 3'b000} +: 8];
      lane_h    = alu_out[1] ? mem_data[31:16] : mem_data[15:0];
      load_data = read_type[1] ? mem_data :
                  read_type[0] ? {{16{~read_type[2] & lane_h[15]}}, lane_h} :
                                 {{24{~read_type[2] & lane_b[7]}}, lane_b};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid     <= 1'b0;
         wb_reg_we    <= 1'b0;
         wb_reg_addr  <= '0;
         wb_reg_data  <= '0;
         wb_hilo_we   <= 1'b0;
         wb_hilo_data <= '0;
         wb_pc        <= '0;
         wb_exc       <= '0;
         wb_is_ds     <= 1'b0;
         retire_cnt   <= '0;
         stall_cnt    <= '0;
      end else begin
         if (stall_mem) stall_cnt <= stall_cnt + 32'd1;
         if (flush) begin
            wb_valid     <= 1'b0;
            wb_reg_we    <= 1'b0;
            wb_reg_addr  <= '0;
            wb_reg_data  <= '0;
            wb_hilo_we   <= 1'b0;
            wb_hilo_data <= '0;
            wb_pc        <= '0;
            wb_exc       <= '0;
            wb_is_ds     <= 1'b0;
         end else if (!hold_wb) begin
            if (stall_mem) begin
               wb_valid   <= 1'b0;
               wb_reg_we  <= 1'b0;
               wb_hilo_we <= 1'b0;
            end else begin
               wb_valid     <= 1'b1;
               wb_reg_we    <= reg_write & (exc_in == 4'd0);
               wb_reg_addr  <= wr_reg;
               wb_reg_data  <= mem_to_reg ? load_data : alu_out;
               wb_hilo_we   <= hilo_we & (exc_in == 4'd0);
               wb_hilo_data <= hilo_data;
               wb_pc        <= pc_in;
               wb_exc       <= exc_in;
               wb_is_ds     <= is_ds_in;
               if (exc_in == 4'd0) retire_cnt <= retire_cnt + 32'd1;
            end
         end
      end
   end
endmodule
